// File: rtl/video_modulator_pkg.sv
// Constants shared by the video modulator multiplier scheduler and the
// multiplier wrapper it feeds.
package video_modulator_pkg;

  localparam int MULT_LATENCY_DEF = 1;
  localparam int OPND_W           = 8;
  localparam int PROD_W           = 16;

endpackage

// File: rtl/video_modulator_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant over req, searching from
// last+1; the last pointer moves to the winner when advance is high.
module video_modulator_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last;
  logic [IW-1:0] win_idx;
  logic          found;
  int            idx;

  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Offset N wraps back to last itself, so a lone requester can win again.
    for (int k = 1; k <= N; k++) begin
      idx = int'(last) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        grant[idx]   = 1'b1;
        win_idx      = IW'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= IW'(N - 1);
    end else if (advance && found) begin
      last <= win_idx;
    end
  end

endmodule

// File: rtl/video_modulator_mult_scheduler.sv
// Shares one paired 8x8 multiplier among NUM_REQ requesters: round-robin
// issue of operand quads and a tag pipeline routing products back.
module video_modulator_mult_scheduler
  import video_modulator_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = MULT_LATENCY_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_mask,
  input  logic [NUM_REQ*OPND_W-1:0] req_1a,
  input  logic [NUM_REQ*OPND_W-1:0] req_1b,
  input  logic [NUM_REQ*OPND_W-1:0] req_2a,
  input  logic [NUM_REQ*OPND_W-1:0] req_2b,
  output logic [OPND_W-1:0]         mult_1a,
  output logic [OPND_W-1:0]         mult_1b,
  output logic [OPND_W-1:0]         mult_2a,
  output logic [OPND_W-1:0]         mult_2b,
  input  logic [PROD_W-1:0]         mult_out_1,
  input  logic [PROD_W-1:0]         mult_out_2,
  output logic [NUM_REQ-1:0]        res_valid,
  output logic [PROD_W-1:0]         res_1,
  output logic [PROD_W-1:0]         res_2,
  output logic                      busy
);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               issue;
  logic [OPND_W-1:0]  sel_1a, sel_1b, sel_2a, sel_2b;
  logic [NUM_REQ-1:0] tag_vld_p [0:MULT_LATENCY];
  logic               busy_any;

  // Holding eligibility low during reset keeps req_ready at zero.
  assign eligible  = rst_n ? (req_valid & req_mask) : '0;
  assign issue     = |grant;
  assign req_ready = grant;

  video_modulator_rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (eligible),
    .advance (issue),
    .grant   (grant)
  );

  always_comb begin
    sel_1a = '0;
    sel_1b = '0;
    sel_2a = '0;
    sel_2b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_1a = req_1a[OPND_W*i +: OPND_W];
        sel_1b = req_1b[OPND_W*i +: OPND_W];
        sel_2a = req_2a[OPND_W*i +: OPND_W];
        sel_2b = req_2b[OPND_W*i +: OPND_W];
      end
    end
  end

  // Stage p0: operand registers feeding the multiplier; zero when idle.
  always_ff @(posedge clk) begin
    if (!rst_n || !issue) begin
      mult_1a <= '0;
      mult_1b <= '0;
      mult_2a <= '0;
      mult_2b <= '0;
    end else begin
      mult_1a <= sel_1a;
      mult_1b <= sel_1b;
      mult_2a <= sel_2a;
      mult_2b <= sel_2b;
    end
  end

  // Stages p0..pL: one-hot owner tags, aligned with the multiplier pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s <= MULT_LATENCY; s++) tag_vld_p[s] <= '0;
    end else begin
      tag_vld_p[0] <= grant;
      for (int s = 1; s <= MULT_LATENCY; s++) tag_vld_p[s] <= tag_vld_p[s-1];
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int s = 0; s <= MULT_LATENCY; s++) busy_any = busy_any | (|tag_vld_p[s]);
  end

  assign busy      = busy_any;
  assign res_valid = tag_vld_p[MULT_LATENCY];
  assign res_1     = mult_out_1;
  assign res_2     = mult_out_2;

endmodule

// File: tb/tb_video_modulator_mult_scheduler.sv
// Directed bench for video_modulator_mult_scheduler with latency-accurate
// multiplier models at MULT_LATENCY 1 and 3.
module tb_video_modulator_mult_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_mask;
  logic [31:0] req_1a, req_1b, req_2a, req_2b;

  logic [3:0]  req_ready, res_valid, req_ready3, res_valid3;
  logic [7:0]  mult_1a, mult_1b, mult_2a, mult_2b;
  logic [7:0]  m3_1a, m3_1b, m3_2a, m3_2b;
  logic [15:0] mult_out_1, mult_out_2, mo3_1, mo3_2;
  logic [15:0] res_1, res_2, res3_1, res3_2;
  logic        busy, busy3;
  logic [15:0] q3_1 [0:2];
  logic [15:0] q3_2 [0:2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_modulator_mult_scheduler #(.NUM_REQ(4), .MULT_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mask(req_mask), .req_1a(req_1a), .req_1b(req_1b), .req_2a(req_2a),
    .req_2b(req_2b), .mult_1a(mult_1a), .mult_1b(mult_1b), .mult_2a(mult_2a),
    .mult_2b(mult_2b), .mult_out_1(mult_out_1), .mult_out_2(mult_out_2),
    .res_valid(res_valid), .res_1(res_1), .res_2(res_2), .busy(busy)
  );

  video_modulator_mult_scheduler #(.NUM_REQ(4), .MULT_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready3),
    .req_mask(req_mask), .req_1a(req_1a), .req_1b(req_1b), .req_2a(req_2a),
    .req_2b(req_2b), .mult_1a(m3_1a), .mult_1b(m3_1b), .mult_2a(m3_2a),
    .mult_2b(m3_2b), .mult_out_1(mo3_1), .mult_out_2(mo3_2),
    .res_valid(res_valid3), .res_1(res3_1), .res_2(res3_2), .busy(busy3)
  );

  // Multiplier models: registered products, 1 and 3 edges of latency.
  always_ff @(posedge clk) begin
    mult_out_1 <= 16'(mult_1a) * 16'(mult_1b);
    mult_out_2 <= 16'(mult_2a) * 16'(mult_2b);
    q3_1[0] <= 16'(m3_1a) * 16'(m3_1b);
    q3_2[0] <= 16'(m3_2a) * 16'(m3_2b);
    q3_1[1] <= q3_1[0];
    q3_2[1] <= q3_2[0];
    q3_1[2] <= q3_1[1];
    q3_2[2] <= q3_2[1];
  end
  assign mo3_1 = q3_1[2];
  assign mo3_2 = q3_2[2];

  function automatic logic [7:0] opv(int c, int i, int k);
    return 8'((c * 37 + i * 11 + k * 53 + 7) % 256);
  endfunction

  function automatic logic [15:0] prod(int c, int i, int ka, int kb);
    return 16'(opv(c, i, ka)) * 16'(opv(c, i, kb));
  endfunction

  task automatic set_ops(int c);
    for (int i = 0; i < 4; i++) begin
      req_1a[8*i +: 8] = opv(c, i, 0);
      req_1b[8*i +: 8] = opv(c, i, 1);
      req_2a[8*i +: 8] = opv(c, i, 2);
      req_2b[8*i +: 8] = opv(c, i, 3);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_mask  = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 4'hF;
    req_mask  = 4'hF;
    set_ops(0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_ready got %b exp 0000", req_ready);
    end
    checks++;
    if (mult_1a !== 8'd0 || mult_2b !== 8'd0 || res_valid !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state mult_1a=%0d mult_2b=%0d res_valid=%b busy=%b exp 0 0 0000 0",
               mult_1a, mult_2b, res_valid, busy);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL reset_first_grant got %b exp 0001", req_ready);
    end
    req_valid = 4'h0;
  endtask

  task automatic test_single_issue();
    apply_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    req_1a = 32'd200; req_1b = 32'd3; req_2a = 32'd15; req_2b = 32'd17;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_ready got %b exp 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    checks++;
    if (mult_1a !== 8'd200 || mult_2b !== 8'd17 || busy !== 1'b1 || res_valid !== 4'h0) begin
      errors++;
      $display("FAIL single_issue mult_1a=%0d mult_2b=%0d busy=%b res_valid=%b exp 200 17 1 0000",
               mult_1a, mult_2b, busy, res_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 4'b0001 || res_1 !== 16'd600 || res_2 !== 16'd255) begin
      errors++;
      $display("FAIL single_result res_valid=%b res_1=%0d res_2=%0d exp 0001 600 255",
               res_valid, res_1, res_2);
    end
    @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_drain res_valid=%b busy=%b exp 0000 0", res_valid, busy);
    end
  endtask

  task automatic test_full_contention();
    int r;
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = (c < 8) ? 4'hF : 4'h0;
      set_ops(c);
      #1;
      if (c < 8) begin
        checks++;
        if (req_ready !== 4'(1 << (c % 4))) begin
          errors++;
          $display("FAIL contention_grant c=%0d got %b exp %b", c, req_ready, 4'(1 << (c % 4)));
        end
      end
      if (c >= 2) begin
        r = (c - 2) % 4;
        checks++;
        if (res_valid !== 4'(1 << r) || res_1 !== prod(c - 2, r, 0, 1) || res_2 !== prod(c - 2, r, 2, 3)) begin
          errors++;
          $display("FAIL contention_result c=%0d res_valid=%b res_1=%0d res_2=%0d exp %b %0d %0d",
                   c, res_valid, res_1, res_2, 4'(1 << r), prod(c - 2, r, 0, 1), prod(c - 2, r, 2, 3));
        end
      end
    end
  endtask

  task automatic test_mask();
    logic [3:0] exp_g [0:2];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b1000;
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_mask  = 4'b1011;
      req_valid = 4'hF;
      set_ops(c);
      #1;
      checks++;
      if (req_ready !== exp_g[c % 3] || req_ready[2] !== 1'b0) begin
        errors++;
        $display("FAIL mask_grant c=%0d got %b exp %b", c, req_ready, exp_g[c % 3]);
      end
    end
    @(negedge clk);
    req_valid = 4'h0;
    req_mask  = 4'hF;
  endtask

  task automatic test_extremes();
    apply_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    req_1a = 32'd255; req_1b = 32'd255; req_2a = 32'd0; req_2b = 32'd255;
    @(negedge clk);
    req_valid = 4'h0;
    @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 4'b0001 || res_1 !== 16'd65025 || res_2 !== 16'd0) begin
      errors++;
      $display("FAIL extreme_product res_valid=%b res_1=%0d res_2=%0d exp 0001 65025 0",
               res_valid, res_1, res_2);
    end
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = (c < 5) ? 4'b1000 : 4'h0;
      set_ops(c);
      #1;
      if (c < 5) begin
        checks++;
        if (req_ready !== 4'b1000) begin
          errors++;
          $display("FAIL b2b_grant c=%0d got %b exp 1000", c, req_ready);
        end
      end
      if (c >= 2) begin
        checks++;
        if (res_valid !== 4'b1000 || res_1 !== prod(c - 2, 3, 0, 1) || res_2 !== prod(c - 2, 3, 2, 3)) begin
          errors++;
          $display("FAIL b2b_result c=%0d res_valid=%b res_1=%0d res_2=%0d exp 1000 %0d %0d",
                   c, res_valid, res_1, res_2, prod(c - 2, 3, 0, 1), prod(c - 2, 3, 2, 3));
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    @(negedge clk);
    req_valid = 4'b0001;
    set_ops(3);
    @(negedge clk);
    req_valid = 4'h0;
    rst_n     = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (res_valid !== 4'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midflight_discard res_valid=%b busy=%b exp 0000 0", res_valid, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    req_valid = 4'hF;
    #1;
    checks++;
    if (req_ready !== 4'b0001 || res_valid !== 4'h0) begin
      errors++;
      $display("FAIL midflight_regrant ready=%b res_valid=%b exp 0001 0000", req_ready, res_valid);
    end
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  task automatic test_latency3();
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid = (c == 0) ? 4'b0010 : 4'h0;
      req_1a = 32'd12 << 8; req_1b = 32'd13 << 8; req_2a = 32'd14 << 8; req_2b = 32'd15 << 8;
      #1;
      if (c == 0) begin
        checks++;
        if (req_ready3 !== 4'b0010) begin
          errors++;
          $display("FAIL lat3_ready got %b exp 0010", req_ready3);
        end
      end else begin
        checks++;
        if (res_valid3 !== ((c == 4) ? 4'b0010 : 4'h0) || busy3 !== (c <= 4)) begin
          errors++;
          $display("FAIL lat3_pipe c=%0d res_valid=%b busy=%b exp %b %b",
                   c, res_valid3, busy3, (c == 4) ? 4'b0010 : 4'h0, (c <= 4));
        end
      end
      if (c == 4) begin
        checks++;
        if (res3_1 !== 16'd156 || res3_2 !== 16'd210) begin
          errors++;
          $display("FAIL lat3_result res_1=%0d res_2=%0d exp 156 210", res3_1, res3_2);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 4'h0;
    req_mask = 4'hF;
    req_1a = '0; req_1b = '0; req_2a = '0; req_2b = '0;
    test_reset();
    test_single_issue();
    test_full_contention();
    test_mask();
    test_extremes();
    test_reset_midflight();
    test_latency3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_modulator_mult_scheduler.md
# video_modulator_mult_scheduler

Time-multiplexes one paired unsigned 8x8 multiplier (two independent 8x8→16 products per issue, fixed registered latency) among `NUM_REQ` requesters in the video modulator, e.g. chroma U/V modulation, luma gain and burst scaling. Each cycle a round-robin arbiter accepts at most one requester's operand quad and registers it into the multiplier inputs. A matching tag pipeline routes the two products back to the issuing requester with a one-hot valid.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MULT_LATENCY`, 1: edges from operands stable at multiplier inputs to products on `mult_out_*`, 1..3.
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in NUM_REQ: requester i has an operand quad.
- `req_ready` out NUM_REQ: one-hot (or zero) grant; handshake is `req_valid[i] & req_ready[i]`.
- `req_mask` in NUM_REQ: 1 = requester eligible; 0 = never granted.
- `req_1a`, `req_1b`, `req_2a`, `req_2b` in NUM_REQ*8: flattened operands, requester i at `[8i+7:8i]`.
- `mult_1a`, `mult_1b`, `mult_2a`, `mult_2b` out 8: registered operands to the multiplier.
- `mult_out_1`, `mult_out_2` in 16: products from the multiplier.
- `res_valid` out NUM_REQ: one-hot; product pair belongs to requester i.
- `res_1`, `res_2` out 16: product pair, broadcast to all requesters.
- `busy` out 1: any issue in flight.

## Operation
- **Arbitration:** combinational round-robin. Priority order starts at `last+1` modulo NUM_REQ over `req_valid & req_mask`. `req_ready` is asserted only for the winner, so `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- **`last` update:** updates to the winner index on every accepted handshake. It is unchanged when no request wins.
- **Issue:** on an accepted handshake the winner's four operands are registered into `mult_*`. On idle cycles `mult_*` load 0.
- **Tag pipeline:** depth 1+MULT_LATENCY, one-hot NUM_REQ bits. Stage 0 loads the grant vector. The final stage drives `res_valid`.
- **Results:** `res_1 = mult_out_1` and `res_2 = mult_out_2`, combinational pass-through. Values are meaningful only when `res_valid != 0`. Products are unsigned, full 16 bits, with no truncation or saturation; 255×255 = 65025.
- **No result backpressure:** a requester must consume its result in the cycle `res_valid` is asserted.
- **`busy`:** OR of all tag stages.
- **Reset (`rst_n` low at an edge):**
  - All tag stages clear and `mult_*` clear to 0.
  - `last` resets to NUM_REQ-1, so requester 0 has first priority.
  - Products in flight are discarded; their `res_valid` never asserts.
  - `req_ready` is forced to 0 while `rst_n` is low.
- **Mask changes:** take effect the same cycle. Masking a requester does not cancel its results already in flight.

## Timing
- **Reset values:** `req_ready` = 0, `mult_*` = 0, `res_valid` = 0, `busy` = 0.
- **Latency:** handshake at edge k → operands on `mult_*` after edge k → `res_valid` asserted in the cycle after edge k+MULT_LATENCY. That is 1+MULT_LATENCY cycles: 2 at the default.
- **Throughput:** one issue per cycle sustained. Back-to-back grants are allowed, including to the same requester when it is the only one eligible.
- **Fairness:** with all requesters continuously valid and unmasked, grants cycle 0,1,…,NUM_REQ-1,0,… exactly.
- **Simultaneous events:** a new grant and a retiring result for the same requester in one cycle are independent. Both occur.
- **Order:** results return in issue order; there is no reordering.

## Structure
- **Shared package** (`video_modulator_pkg`) holds the `MULT_LATENCY` default constant and the operand/product width constants (8, 16). These are shared with the multiplier wrapper.
- **Sub-module:** `video_modulator_rr_arbiter`. Parameter N; inputs `clk`, `rst_n`, `req`, `advance`; output one-hot `grant`. It contains the `last` pointer and the rotate-priority logic.
- **Top level:** operand mux, operand registers, tag shift register and `busy`.
- The multiplier is not instantiated here. The parent connects `mult_*` to it, and the bench uses a latency-accurate model.

## Test plan
- **Single issue:** req0 valid, 1a=200, 1b=3, 2a=15, 2b=17 → `req_ready`=0001 the same cycle; two cycles later `res_valid`=0001, `res_1`=600, `res_2`=255.
- **Full contention:** all four valid for 8 cycles → grants 0,1,2,3,0,1,2,3. Each requester receives its own products, checked against a reference model, in issue order.
- **Mask:** `req_mask`=1011 with all valid → grants cycle 0,1,3. Requester 2 is never granted; `req_ready[2]`=0 throughout.
- **Extremes:** operands 255×255 and 0×255 → `res_1`=65025 and `res_2`=0. Only requester 3 valid for 5 consecutive cycles → 5 back-to-back results.
- **Reset mid-flight:** issue at edge k, then `rst_n` low at edge k+1 → `res_valid` stays 0 and `busy`=0. Post-reset, with all requesters valid, requester 0 is granted first.
- **Latency parameter:** MULT_LATENCY=3 → `res_valid` asserted 4 cycles after the handshake. `busy` stays high until the last tag retires.
